seq_detect_compare: RTL and testbench

SEQ_DETECT_COMPARE -- requirements
Module: seq_detect_compare

---
 rtl/seq_detect_compare.sv | 98 +++++++++
 tb/tb_seq_detect_compare.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/seq_detect_compare.sv
// seq_detect_compare: step-driven Moore and Mealy detectors for one serial pattern,
// cross-checked against each other, with a saturating Moore hit counter.
module seq_detect_compare #(
  parameter int N = 4,
  parameter PATTERN = 4'b1011,
  parameter bit OVERLAP = 1'b1,
  parameter int CNT_W = 8
) (
  input  logic CLK,
  input  logic RST,
  input  logic STEP,
  input  logic A,
  output logic Z_moore,
  output logic [$clog2(N+1)-1:0] S_moore,
  output logic Z_mealy,
  output logic [$clog2(N)-1:0] S_mealy,
  output logic [CNT_W-1:0] HITS,
  output logic MISMATCH
);
  localparam int MW = $clog2(N+1);
  localparam int LW = $clog2(N);
  localparam logic [N-1:0] PAT = N'(PATTERN);
  if (N < 2 || N > 8 || $bits(PATTERN) != N) begin : g_bad_param
    $error("seq_detect_compare: N must be 2..8 and PATTERN exactly N bits wide");
  end
  // Longest suffix of (first k pattern bits, then b) that is also a pattern prefix, capped at lim
  function automatic int nxt(int k, logic b, int lim);
    int best;
    logic ok;
    logic c;
    best = 0;
    for (int j = 1; j <= N; j++) begin
      ok = (j <= k + 1) && (j <= lim);
      for (int t = 0; t < N; t++) begin
        if (ok && t < j) begin
          c = (k + 1 - j + t < k) ? PAT[N-1-(k+1-j+t)] : b;
          ok = (c == PAT[N-1-t]);
        end
      end
      if (ok) best = j;
    end
    return best;
  endfunction
  logic [MW-1:0] mo_nx [0:N][0:1];
  logic [LW-1:0] me_nx [0:N-1][0:1];
  for (genvar k = 0; k <= N; k++) begin : g_mo
    for (genvar b = 0; b < 2; b++) begin : g_b
      assign mo_nx[k][b] = MW'((k == N && !OVERLAP) ? nxt(0, b == 1, N) : nxt(k, b == 1, N));
    end
  end
  for (genvar k = 0; k < N; k++) begin : g_me
    for (genvar b = 0; b < 2; b++) begin : g_b
      assign me_nx[k][b] = LW'((k == N-1 && (b == 1) == PAT[0] && !OVERLAP) ? 0 : nxt(k, b == 1, N-1));
    end
  end
  logic [1:0] step_sync_q, a_sync_q;
  logic step_q, chk_q, hq_q, mis_q, mis_d, stp, a_s;
  logic [MW-1:0] s_moore_q, s_moore_d;
  logic [LW-1:0] s_mealy_q, s_mealy_d;
  logic [CNT_W-1:0] hits_q, hits_d;
  assign a_s = a_sync_q[1];
  assign stp = step_sync_q[1] & ~step_q;
  assign Z_moore = (s_moore_q == MW'(N));
  assign Z_mealy = (s_mealy_q == LW'(N-1)) & (a_s == PAT[0]) & stp;
  always_comb begin
    s_moore_d = stp ? mo_nx[s_moore_q][a_s] : s_moore_q;
    s_mealy_d = stp ? me_nx[s_mealy_q][a_s] : s_mealy_q;
    hits_d = (chk_q && Z_moore && hits_q != '1) ? hits_q + CNT_W'(1) : hits_q;
    mis_d = mis_q | (chk_q & (Z_moore ^ hq_q));
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      step_sync_q <= '0;
      a_sync_q <= '0;
      step_q <= 1'b0;
      chk_q <= 1'b0;
      hq_q <= 1'b0;
      mis_q <= 1'b0;
      s_moore_q <= '0;
      s_mealy_q <= '0;
      hits_q <= '0;
    end else begin
      step_sync_q <= {step_sync_q[0], STEP};
      a_sync_q <= {a_sync_q[0], A};
      step_q <= step_sync_q[1];
      chk_q <= stp;
      hq_q <= stp ? Z_mealy : hq_q;
      mis_q <= mis_d;
      s_moore_q <= s_moore_d;
      s_mealy_q <= s_mealy_d;
      hits_q <= hits_d;
    end
  end
  assign S_moore = s_moore_q;
  assign S_mealy = s_mealy_q;
  assign HITS = hits_q;
  assign MISMATCH = mis_q;
endmodule

// File: tb/tb_seq_detect_compare.sv
// tb_seq_detect_compare: directed bench over four parameterisations sharing clock, reset, STEP and A.
module tb_seq_detect_compare;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic step = 1'b0;
  logic a = 1'b0;
  int checks = 0;
  int errors = 0;
  logic zm0, zm1, zm2, zm3, zl0, zl1, zl2, zl3, mis0, mis1, mis2, mis3;
  logic [2:0] sm0, sm1, sm2;
  logic [1:0] sl0, sl1, sl2, sm3, sl3;
  logic [7:0] h0, h1, h3;
  logic [1:0] h2;
  logic [3:0] mseen;
  logic [2:0] lat2, lat3;
  logic [6:0] s1 = 7'b1011011;
  logic [6:0] e0 = 7'b0001001;
  logic [6:0] e1 = 7'b0001000;
  logic [3:0] pat = 4'b1011;

  always #5 clk = ~clk;

  seq_detect_compare u0 (.CLK(clk), .RST(rst), .STEP(step), .A(a), .Z_moore(zm0), .S_moore(sm0),
    .Z_mealy(zl0), .S_mealy(sl0), .HITS(h0), .MISMATCH(mis0));
  seq_detect_compare #(.OVERLAP(0)) u1 (.CLK(clk), .RST(rst), .STEP(step), .A(a), .Z_moore(zm1),
    .S_moore(sm1), .Z_mealy(zl1), .S_mealy(sl1), .HITS(h1), .MISMATCH(mis1));
  seq_detect_compare #(.OVERLAP(0), .CNT_W(2)) u2 (.CLK(clk), .RST(rst), .STEP(step), .A(a),
    .Z_moore(zm2), .S_moore(sm2), .Z_mealy(zl2), .S_mealy(sl2), .HITS(h2), .MISMATCH(mis2));
  seq_detect_compare #(.N(3), .PATTERN(3'b111), .OVERLAP(1)) u3 (.CLK(clk), .RST(rst), .STEP(step),
    .A(a), .Z_moore(zm3), .S_moore(sm3), .Z_mealy(zl3), .S_mealy(sl3), .HITS(h3), .MISMATCH(mis3));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clean step: A settles, STEP pulses long enough, Mealy pulses are collected while STEP is high
  task automatic do_step(input logic b);
    a = b;
    repeat (3) @(negedge clk);
    step = 1'b1;
    mseen = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      mseen = mseen | {zl3, zl2, zl1, zl0};
      if (i == 1) lat2 = sm0;
      if (i == 2) lat3 = sm0;
    end
    step = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic rst_pulse();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_smoore", sm0, 0);
    chk("rst_smealy", sl0, 0);
    chk("rst_zmoore", zm0, 0);
    chk("rst_zmealy", zl0, 0);
    chk("rst_hits", h0, 0);
    chk("rst_mismatch", mis0, 0);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 6; i >= 0; i--) begin
      do_step(s1[i]);
      if (i == 6) begin
        chk("latency_before", lat2, 0);
        chk("latency_after", lat3, 1);
      end
      chk("t1_zmoore_ov", zm0, e0[i]);
      chk("t1_zmoore_nov", zm1, e1[i]);
      chk("t1_zmealy_ov", mseen[0], e0[i]);
      chk("t1_zmealy_nov", mseen[1], e1[i]);
      if (i == 2) chk("t1_smoore_nov_restart", sm1, 0);
    end
    chk("t1_hits_ov", h0, 2);
    chk("t1_hits_nov", h1, 1);
    chk("t1_hits_cnt2", h2, 1);
    chk("t1_hits_n3", h3, 0);
    chk("t1_mis_ov", mis0, 0);
    chk("t1_mis_nov", mis1, 0);
    chk("t1_mis_n3", mis3, 0);
    rst_pulse();
    step = 1'b1;
    a = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      a = ~a;
    end
    step = 1'b0;
    repeat (3) @(negedge clk);
    chk("t2_held_smoore", sm0, 1);
    chk("t2_held_smealy", sl0, 1);
    chk("t2_held_smoore_n3", sm3, 1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      a = ~a;
    end
    chk("t2_idle_smoore", sm0, 1);
    chk("t2_idle_smealy", sl0, 1);
    chk("t2_mis", mis0, 0);
    chk("t2_mis_n3", mis3, 0);
    rst_pulse();
    do_step(1'b1);
    do_step(1'b0);
    do_step(1'b1);
    chk("t3_mid_smoore", sm0, 3);
    rst = 1'b1;
    #1;
    chk("t3_async_smoore", sm0, 0);
    chk("t3_async_smealy", sl0, 0);
    @(negedge clk);
    rst = 1'b0;
    do_step(1'b1);
    chk("t3_smoore", sm0, 1);
    chk("t3_smealy", sl0, 1);
    chk("t3_hits", h0, 0);
    chk("t3_zmoore", zm0, 0);
    chk("t3_zmealy", mseen[0], 0);
    rst_pulse();
    for (int r = 0; r < 5; r++) begin
      for (int j = 3; j >= 0; j--) do_step(pat[j]);
      chk("t4_hits_sat", h2, (r + 1 > 3) ? 3 : r + 1);
      chk("t4_mis_sat", mis2, 0);
    end
    chk("t4_hits_nov", h1, 5);
    chk("t4_hits_ov", h0, 5);
    chk("t4_mis_ov", mis0, 0);
    rst_pulse();
    for (int i = 1; i <= 5; i++) begin
      do_step(1'b1);
      chk("t5_zmoore_111", zm3, (i >= 3) ? 1 : 0);
      chk("t5_zmealy_111", mseen[3], (i >= 3) ? 1 : 0);
    end
    chk("t5_smoore_111", sm3, 3);
    chk("t5_smealy_111", sl3, 2);
    chk("t5_hits_111", h3, 3);
    chk("t5_mis_111", mis3, 0);
    @(negedge clk);
    rst = 1'b1;
    step = 1'b1;
    a = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6_inrst_smoore", sm0, 0);
    chk("t6_inrst_zmealy", zl0, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_release_step", sm0, 1);
    repeat (10) @(negedge clk);
    chk("t6_single_step", sm0, 1);
    step = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1);
  end
endmodule
